adder_tree_acc: RTL and testbench
=================================

ADDER_TREE_ACC -- requirements
Module: adder_tree_acc

Interface
REQ-001 Parameter NUM_INPUTS, default 37, number of operands (legal range 2..1024).
REQ-002 Parameter DATA_WIDTH, default 8, width of each operand.
REQ-003 Parameter SIGNED, default 0; 0 means unsigned operands, 1 means two's-complement operands.
REQ-004 Parameter ACC_BITS, default 8, headroom bits added for frame accumulation.
REQ-005 Parameter BEAT_WIDTH, default 16, width of the beat counter.
REQ-006 Derived LAT = ceil(log2(NUM_INPUTS)) and RESULT_WIDTH = DATA_WIDTH + LAT + ACC_BITS.
REQ-007 Clocking: one clock; reset is asynchronous and active-low.
REQ-008 clk  in  1  rising-edge clock for all state.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 din_valid  in  1  current din beat is valid.
REQ-011 din_last  in  1  last beat of a frame; qualified by din_valid.
REQ-012 acc_mode  in  1  0 = per-beat sum, 1 = frame accumulation; sampled with each valid beat.
REQ-013 din  in  NUM_INPUTS*DATA_WIDTH  packed operands, operand k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 dout_valid  out  1  dout, dout_beats and dout_ovf are valid.
REQ-015 dout  out  RESULT_WIDTH  sum, sign- or zero-extended according to SIGNED.
REQ-016 dout_beats  out  BEAT_WIDTH  number of beats contributing to dout.
REQ-017 dout_ovf  out  1  the accumulation wrapped at RESULT_WIDTH during this frame.

Function
REQ-018 The tree SHALL have LAT registered levels; level L pairs adjacent nodes (node 2j with node 2j+1), and each result is DATA_WIDTH+L bits wide.
REQ-019 An odd leftover node at any level SHALL pass through a register, extended by 1 bit (sign-extended if SIGNED=1, zero-extended otherwise).
REQ-020 The tree SHALL never overflow; it is exact by construction.
REQ-021 din_valid, din_last and acc_mode SHALL travel down a LAT-deep valid/tag pipeline alongside the data; invalid beats never affect the outputs.
REQ-022 An accumulator stage SHALL follow the tree, giving a total latency of LAT+1 cycles from the valid beat to dout_valid.
REQ-023 Accumulator FSM SHALL have states IDLE and OPEN.
REQ-024 Mode-0 beat: dout = tree sum, dout_beats = 1, dout_ovf = 0; if OPEN, the partial frame is discarded with no output and the FSM goes to IDLE.
REQ-025 Mode-1 beat with last=0: acc <= (IDLE ? 0 : acc) + tree sum, beats increments, FSM goes to OPEN, no output.
REQ-026 Mode-1 beat with last=1: output the final acc+sum, beats+1 and ovf; the FSM goes to IDLE with the same edge.
REQ-027 A single-beat frame (IDLE, mode 1, last=1) SHALL emit that beat's sum with dout_beats = 1.
REQ-028 Back-to-back frames with no gap SHALL be supported; the next frame starts from 0.
REQ-029 Accumulation SHALL wrap modulo 2^RESULT_WIDTH; dout_ovf is sticky per frame and set on unsigned carry-out, or on signed overflow when SIGNED=1.
REQ-030 dout_beats SHALL saturate at 2^BEAT_WIDTH-1.
REQ-031 dout_valid SHALL be a single-cycle pulse per result; dout, dout_beats and dout_ovf hold their value between pulses.
REQ-032 Throughput SHALL be one beat per cycle, with no backpressure.

Reset
REQ-033 On rst_n low: all valid/tag bits 0, FSM IDLE, acc 0, beat count 0, dout 0, dout_beats 0, dout_ovf 0, dout_valid 0.
REQ-034 Reset mid-frame or mid-pipeline SHALL drop all in-flight beats; no dout_valid is produced for them after release.
REQ-035 Tree data registers MAY be non-reset; valid bits SHALL be reset.

Structure
REQ-036 Package adder_tree_pkg SHALL hold the clog2 function, the level-width and node-count functions, and the FSM state enum.
REQ-037 Sub-module adder_tree_node SHALL implement a registered 2-input add or a registered 1-input extend, parametrised by input width and SIGNED.
REQ-038 Levels SHALL be built with generate loops; the design has no hand-enumerated ports.

Verification (NUM_INPUTS=37, DATA_WIDTH=8, LAT=6, RESULT_WIDTH=22)
REQ-039 Mode 0, unsigned, all operands 0xFF -> dout=9435, dout_beats=1, dout_valid exactly 7 cycles after the beat.
REQ-040 SIGNED=1, mode 0, all operands 0xFF -> dout = -37 (0x3FFFDB), dout_ovf=0.
REQ-041 Mode 1, 3 beats of all-1 operands with last on the 3rd beat, then an immediate 2-beat frame of all-2 operands -> two pulses: (111, beats 3) and (148, beats 2).
REQ-042 Mode 1, 445 beats of all-0xFF operands -> dout=4271, dout_ovf=1; the same test with 444 beats -> dout=4189140, dout_ovf=0.
REQ-043 Open frame, then a mode-0 beat of all-1 operands -> the only output is 37 with beats=1; the aborted frame emits nothing.
REQ-044 rst_n pulsed low after 2 beats of an open frame while beats are in flight -> no dout_valid until new post-reset beats arrive, and all outputs read 0.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// Shared types and elaboration-time helpers for the adder tree accumulator.
package adder_tree_pkg;

    // Accumulator frame state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } acc_state_e;

    // Ceiling log2; returns 0 for n <= 1
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Width of every node result at tree level lvl (level 0 is the raw operands)
    function automatic int unsigned level_width(input int unsigned data_width, input int unsigned lvl);
        return data_width + lvl;
    endfunction

    // Number of nodes present at tree level lvl
    function automatic int unsigned node_count(input int unsigned num_inputs, input int unsigned lvl);
        int unsigned c;
        c = num_inputs;
        for (int unsigned i = 0; i < lvl; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

endpackage

// File: rtl/adder_tree_node.sv
// One registered tree node: sum of two operands, or a one-bit extension of a lone operand.
module adder_tree_node #(
    parameter int unsigned IN_WIDTH = 8,
    parameter bit          SIGNED   = 1'b0,
    parameter bit          PAIR     = 1'b1
) (
    input  logic                clk,
    input  logic [IN_WIDTH-1:0] a,
    input  logic [IN_WIDTH-1:0] b,
    output logic [IN_WIDTH:0]   sum
);

    logic [IN_WIDTH:0] ext_a_c;
    logic [IN_WIDTH:0] ext_b_c;
    logic [IN_WIDTH:0] sum_c;

    // Extend both operands by one bit, then add (or pass a through for a lone node)
    always_comb begin
        ext_a_c = {SIGNED & a[IN_WIDTH-1], a};
        ext_b_c = {SIGNED & b[IN_WIDTH-1], b};
        sum_c   = PAIR ? (ext_a_c + ext_b_c) : ext_a_c;
    end

    // Data register; no reset needed, validity travels in the tag pipeline
    always_ff @(posedge clk) begin
        sum <= sum_c;
    end

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined adder tree over NUM_INPUTS operands followed by a per-beat / per-frame accumulator.
module adder_tree_acc
    import adder_tree_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 37,
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          SIGNED     = 1'b0,
    parameter int unsigned ACC_BITS   = 8,
    parameter int unsigned BEAT_WIDTH = 16,
    localparam int unsigned LAT          = clog2(NUM_INPUTS),
    localparam int unsigned RESULT_WIDTH = DATA_WIDTH + LAT + ACC_BITS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             din_valid,
    input  logic                             din_last,
    input  logic                             acc_mode,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] din,
    output logic                             dout_valid,
    output logic [RESULT_WIDTH-1:0]          dout,
    output logic [BEAT_WIDTH-1:0]            dout_beats,
    output logic                             dout_ovf
);

    localparam int unsigned TREE_WIDTH = level_width(DATA_WIDTH, LAT);

    // Tree levels: level l reduces level l-1 pairwise, lone last node is extended
    for (genvar l = 1; l <= LAT; l++) begin : g_lvl
        localparam int unsigned IW = level_width(DATA_WIDTH, l - 1);
        localparam int unsigned NI = node_count(NUM_INPUTS, l - 1);
        localparam int unsigned NO = node_count(NUM_INPUTS, l);

        logic [NI*IW-1:0]     src;
        logic [NO*(IW+1)-1:0] res;

        if (l == 1) begin : g_src_in
            assign src = din;
        end else begin : g_src_lvl
            assign src = g_lvl[l-1].res;
        end

        for (genvar j = 0; j < NO; j++) begin : g_node
            if (2 * j + 1 < NI) begin : g_pair
                adder_tree_node #(
                    .IN_WIDTH (IW),
                    .SIGNED   (SIGNED),
                    .PAIR     (1'b1)
                ) u_node (
                    .clk (clk),
                    .a   (src[(2*j)*IW +: IW]),
                    .b   (src[(2*j+1)*IW +: IW]),
                    .sum (res[j*(IW+1) +: IW+1])
                );
            end else begin : g_single
                adder_tree_node #(
                    .IN_WIDTH (IW),
                    .SIGNED   (SIGNED),
                    .PAIR     (1'b0)
                ) u_node (
                    .clk (clk),
                    .a   (src[(2*j)*IW +: IW]),
                    .b   ('0),
                    .sum (res[j*(IW+1) +: IW+1])
                );
            end
        end
    end

    logic [TREE_WIDTH-1:0] tree_sum;
    assign tree_sum = g_lvl[LAT].res;

    logic [LAT-1:0] v_pipe;
    logic [LAT-1:0] l_pipe;
    logic [LAT-1:0] m_pipe;

    // Valid/tag pipeline aligned with the tree levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_pipe <= '0;
            l_pipe <= '0;
            m_pipe <= '0;
        end else begin
            v_pipe[0] <= din_valid;
            l_pipe[0] <= din_valid & din_last;
            m_pipe[0] <= din_valid & acc_mode;
            for (int i = 1; i < int'(LAT); i++) begin
                v_pipe[i] <= v_pipe[i-1];
                l_pipe[i] <= l_pipe[i-1];
                m_pipe[i] <= m_pipe[i-1];
            end
        end
    end

    acc_state_e                state;
    logic [RESULT_WIDTH-1:0]   acc;
    logic [BEAT_WIDTH-1:0]     frame_beats;
    logic                      frame_ovf;

    logic [RESULT_WIDTH-1:0]   sum_ext_c;
    logic [RESULT_WIDTH-1:0]   base_c;
    logic [RESULT_WIDTH-1:0]   acc_next_c;
    logic                      carry_c;
    logic                      ovf_next_c;
    logic [BEAT_WIDTH-1:0]     beats_base_c;
    logic [BEAT_WIDTH-1:0]     beats_next_c;

    // Next accumulator value; an IDLE frame restarts from zero
    always_comb begin
        if (SIGNED) sum_ext_c = RESULT_WIDTH'(signed'(tree_sum));
        else        sum_ext_c = RESULT_WIDTH'(tree_sum);
        base_c       = (state == ST_OPEN) ? acc : '0;
        beats_base_c = (state == ST_OPEN) ? frame_beats : '0;
        {carry_c, acc_next_c} = {1'b0, base_c} + {1'b0, sum_ext_c};
        ovf_next_c = (state == ST_OPEN) & frame_ovf;
        if (SIGNED) begin
            if ((base_c[RESULT_WIDTH-1] == sum_ext_c[RESULT_WIDTH-1]) &&
                (acc_next_c[RESULT_WIDTH-1] != base_c[RESULT_WIDTH-1])) ovf_next_c = 1'b1;
        end else begin
            if (carry_c) ovf_next_c = 1'b1;
        end
        beats_next_c = (beats_base_c == '1) ? beats_base_c : beats_base_c + BEAT_WIDTH'(1);
    end

    // Accumulator FSM with registered outputs; dout fields hold between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            acc         <= '0;
            frame_beats <= '0;
            frame_ovf   <= 1'b0;
            dout_valid  <= 1'b0;
            dout        <= '0;
            dout_beats  <= '0;
            dout_ovf    <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (v_pipe[LAT-1]) begin
                if (!m_pipe[LAT-1]) begin
                    dout       <= sum_ext_c;
                    dout_beats <= BEAT_WIDTH'(1);
                    dout_ovf   <= 1'b0;
                    dout_valid <= 1'b1;
                    state      <= ST_IDLE;
                end else if (l_pipe[LAT-1]) begin
                    dout       <= acc_next_c;
                    dout_beats <= beats_next_c;
                    dout_ovf   <= ovf_next_c;
                    dout_valid <= 1'b1;
                    state      <= ST_IDLE;
                end else begin
                    acc         <= acc_next_c;
                    frame_beats <= beats_next_c;
                    frame_ovf   <= ovf_next_c;
                    state       <= ST_OPEN;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Self-checking bench for adder_tree_acc: table vectors, random model traffic and corner sequences.
module tb_adder_tree_acc;

    localparam int unsigned N  = 37;
    localparam int unsigned DW = 8;
    localparam int unsigned RW = 22;
    localparam int unsigned BW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            din_valid;
    logic            din_last;
    logic            acc_mode;
    logic [N*DW-1:0] din;
    logic            dout_valid;
    logic [RW-1:0]   dout;
    logic [BW-1:0]   dout_beats;
    logic            dout_ovf;

    logic            s_valid;
    logic            s_dout_valid;
    logic [RW-1:0]   s_dout;
    logic [BW-1:0]   s_beats;
    logic            s_ovf;

    adder_tree_acc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .acc_mode   (acc_mode),
        .din        (din),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_beats (dout_beats),
        .dout_ovf   (dout_ovf)
    );

    adder_tree_acc #(.SIGNED(1'b1)) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (s_valid),
        .din_last   (din_last),
        .acc_mode   (acc_mode),
        .din        (din),
        .dout_valid (s_dout_valid),
        .dout       (s_dout),
        .dout_beats (s_beats),
        .dout_ovf   (s_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] dout;
        logic [BW-1:0] beats;
        logic          ovf;
    } exp_t;

    typedef struct {
        logic          mode;
        logic          last;
        logic [DW-1:0] fill;
        logic          emit;
        logic [RW-1:0] dout;
        logic [BW-1:0] beats;
        logic          ovf;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic logic [N*DW-1:0] fill_all(input logic [DW-1:0] v);
        logic [N*DW-1:0] r;
        for (int k = 0; k < int'(N); k++) r[k*DW +: DW] = v;
        return r;
    endfunction

    task automatic push(input logic [RW-1:0] d, input logic [BW-1:0] b, input logic o);
        exp_t e;
        e.dout  = d;
        e.beats = b;
        e.ovf   = o;
        sb.push_back(e);
    endtask

    task automatic beat(input logic m, input logic l, input logic [N*DW-1:0] d);
        din_valid = 1'b1;
        acc_mode  = m;
        din_last  = l;
        din       = d;
        @(negedge clk);
    endtask

    // Idle cycles carry garbage on the data/tag inputs, which must be ignored
    task automatic idle(input int n);
        din_valid = 1'b0;
        din_last  = 1'b1;
        acc_mode  = 1'($urandom_range(0, 1));
        for (int k = 0; k < int'(N); k++) din[k*DW +: DW] = DW'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (sb.size() != 0 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check(name, sb.size(), 0);
    endtask

    // Scoreboard: every result pulse must match the oldest pending expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && dout_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got dout %0d with nothing expected", dout);
            end else begin
                e = sb.pop_front();
                check("dout", dout, e.dout);
                check("dout_beats", dout_beats, e.beats);
                check("dout_ovf", dout_ovf, e.ovf);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t            tbl[12];
        logic            m_open;
        longint          m_acc;
        longint          m_beats;
        logic            m_ovf;
        int              lat;
        int              pulses;

        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 22'd0,     16'd1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 22'd9435,  16'd1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'h01, 1'b1, 22'd37,    16'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'h80, 1'b1, 22'd4736,  16'd1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 8'h0A, 1'b1, 22'd370,   16'd1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h03, 1'b0, 22'd0,     16'd0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h04, 1'b0, 22'd0,     16'd0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'h05, 1'b1, 22'd444,   16'd3, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h07, 1'b0, 22'd0,     16'd0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h02, 1'b1, 22'd74,    16'd1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'hFF, 1'b0, 22'd0,     16'd0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 8'hFF, 1'b1, 22'd18870, 16'd2, 1'b0};

        rst_n     = 1'b0;
        din_valid = 1'b0;
        s_valid   = 1'b0;
        din_last  = 1'b0;
        acc_mode  = 1'b0;
        din       = '0;
        repeat (3) @(negedge clk);
        check("reset_dout_valid", dout_valid, 0);
        check("reset_dout", dout, 0);
        check("reset_dout_beats", dout_beats, 0);
        check("reset_dout_ovf", dout_ovf, 0);
        rst_n = 1'b1;
        idle(2);

        // Table vectors, back-to-back
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].emit) push(tbl[i].dout, tbl[i].beats, tbl[i].ovf);
            beat(tbl[i].mode, tbl[i].last, fill_all(tbl[i].fill));
        end
        idle(1);
        drain("table_drain");

        // Latency of a mode-0 beat and hold of outputs afterwards
        push(22'd9435, 16'd1, 1'b0);
        din_valid = 1'b1;
        acc_mode  = 1'b0;
        din_last  = 1'b0;
        din       = fill_all(8'hFF);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) din_valid = 1'b0;
            if (dout_valid) begin
                lat = c;
                break;
            end
        end
        check("latency", lat, 7);
        idle(3);
        check("hold_dout", dout, 9435);
        check("hold_valid_low", dout_valid, 0);
        drain("latency_drain");

        // Two back-to-back frames
        push(22'd111, 16'd3, 1'b0);
        push(22'd148, 16'd2, 1'b0);
        beat(1'b1, 1'b0, fill_all(8'h01));
        beat(1'b1, 1'b0, fill_all(8'h01));
        beat(1'b1, 1'b1, fill_all(8'h01));
        beat(1'b1, 1'b0, fill_all(8'h02));
        beat(1'b1, 1'b1, fill_all(8'h02));
        idle(1);
        drain("frames_drain");

        // Wrap boundary: 445 beats wraps, 444 beats does not
        push(22'd4271, 16'd445, 1'b1);
        for (int i = 0; i < 444; i++) beat(1'b1, 1'b0, fill_all(8'hFF));
        beat(1'b1, 1'b1, fill_all(8'hFF));
        push(22'd4189140, 16'd444, 1'b0);
        for (int i = 0; i < 443; i++) beat(1'b1, 1'b0, fill_all(8'hFF));
        beat(1'b1, 1'b1, fill_all(8'hFF));
        idle(1);
        drain("wrap_drain");

        // Open frame aborted by a mode-0 beat; next frame starts from zero
        beat(1'b1, 1'b0, fill_all(8'h05));
        beat(1'b1, 1'b0, fill_all(8'h06));
        push(22'd37, 16'd1, 1'b0);
        beat(1'b0, 1'b0, fill_all(8'h01));
        push(22'd74, 16'd1, 1'b0);
        beat(1'b1, 1'b1, fill_all(8'h02));
        idle(1);
        drain("abort_drain");

        // Random traffic against a behavioural model
        m_open  = 1'b0;
        m_acc   = 0;
        m_beats = 0;
        m_ovf   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            logic [N*DW-1:0] d;
            longint          s;
            longint          t;
            longint          nb;
            logic            o;
            logic            m;
            logic            l;
            s = 0;
            for (int k = 0; k < int'(N); k++) begin
                d[k*DW +: DW] = DW'($urandom);
                s += longint'(d[k*DW +: DW]);
            end
            m = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 3) == 0);
            if (i == 199) m = 1'b0;
            if (!m) begin
                push(RW'(s), BW'(1), 1'b0);
                m_open = 1'b0;
            end else begin
                t  = (m_open ? m_acc : 0) + s;
                o  = (m_open && m_ovf) || (t >= (longint'(1) << RW));
                t  = t % (longint'(1) << RW);
                nb = (m_open ? m_beats : 0) + 1;
                if (l) begin
                    push(RW'(t), BW'(nb), o);
                    m_open = 1'b0;
                end else begin
                    m_acc   = t;
                    m_beats = nb;
                    m_ovf   = o;
                    m_open  = 1'b1;
                end
            end
            beat(m, l, d);
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);
        drain("random_drain");

        // Signed instance: all-ones operands sum to -37
        acc_mode = 1'b0;
        din_last = 1'b0;
        din      = fill_all(8'hFF);
        s_valid  = 1'b1;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) s_valid = 1'b0;
            if (s_dout_valid) begin
                lat = c;
                break;
            end
        end
        check("signed_latency", lat, 7);
        check("signed_dout", s_dout, 22'h3FFFDB);
        check("signed_beats", s_beats, 1);
        check("signed_ovf", s_ovf, 0);
        idle(2);

        // Reset with an open frame and a mode-0 beat in flight
        beat(1'b1, 1'b0, fill_all(8'h03));
        beat(1'b1, 1'b0, fill_all(8'h04));
        beat(1'b0, 1'b0, fill_all(8'h09));
        din_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("midrst_dout_valid", dout_valid, 0);
        check("midrst_dout", dout, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dout_valid) pulses++;
        end
        check("post_reset_pulses", pulses, 0);
        check("post_reset_dout", dout, 0);
        check("post_reset_beats", dout_beats, 0);
        check("post_reset_ovf", dout_ovf, 0);
        push(22'd37, 16'd1, 1'b0);
        beat(1'b0, 1'b0, fill_all(8'h01));
        push(22'd74, 16'd1, 1'b0);
        beat(1'b1, 1'b1, fill_all(8'h02));
        idle(1);
        drain("reset_drain");

        idle(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
